// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: state encodings, default
// geometry, the captured-request payload and the address legality check.
package data_memory_responder_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned DEFAULT_LATENCY    = 2;
  localparam int unsigned DATA_WIDTH         = 32;
  localparam int unsigned BUS_ADDR_WIDTH     = 32;
  localparam int unsigned CNT_WIDTH          = 4;

  // Responder FSM states; encodings are fixed so traces match the CPU-side docs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One load/store request as seen on the request channel.
  typedef struct packed {
    logic                      we;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
  } req_t;

  // A byte address is illegal when it is not word aligned or lies above the RAM.
  function automatic logic addr_error(input logic [BUS_ADDR_WIDTH-1:0] addr,
                                      input int unsigned               aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/data_memory_responder_memory_array.sv
// memory_array: single-port word RAM, synchronous write, registered read.
// Ports:
//   clk  - rising-edge clock
//   we   - write enable for this edge
//   addr - word address
//   din  - write data
//   dout - read data, registered (old contents on a same-edge write)
module memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder side of the CPU data-memory port. Accepts one
// load/store at a time over valid/ready, waits LATENCY cycles, performs the RAM
// access and holds the response until the CPU takes it.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   req_valid/req_ready    - request handshake (ready only in IDLE)
//   req_we/addr/wdata      - store flag, byte address, store data
//   resp_valid/resp_ready  - response handshake
//   resp_rdata             - load data (0 for stores and errors)
//   resp_err               - misaligned or out-of-range address
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned LATENCY    = DEFAULT_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err
);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  req_t                  cap, cap_n;
  req_t                  cur_c;
  logic                  req_ready_n;
  logic                  resp_valid_n;
  logic                  resp_err_n;
  logic                  rdata_en, rdata_en_n;
  logic                  access_c;
  logic                  err_c;
  logic                  ram_we_c;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Request being worked on: live inputs while idle (so a zero-latency access can
  // use them on the accepting edge), the captured copy otherwise.
  always_comb begin
    cur_c = cap;
    if (state == ST_IDLE) begin
      cur_c.we    = req_we;
      cur_c.addr  = req_addr;
      cur_c.wdata = req_wdata;
    end
  end

  assign err_c    = addr_error(cur_c.addr, ADDR_WIDTH);
  assign ram_we_c = access_c & cur_c.we & ~err_c;

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cap_n        = cap;
    req_ready_n  = req_ready;
    resp_valid_n = resp_valid;
    resp_err_n   = resp_err;
    rdata_en_n   = rdata_en;
    access_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          cap_n       = cur_c;
          req_ready_n = 1'b0;
          if (LATENCY == 0) begin
            access_c = 1'b1;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = CNT_WIDTH'(LATENCY) - CNT_WIDTH'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          access_c = 1'b1;
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
          req_ready_n  = 1'b1;
        end
      end
      default: begin
        state_n      = ST_IDLE;
        req_ready_n  = 1'b1;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
      end
    endcase

    // The access edge always enters RESP with the response fields set.
    if (access_c) begin
      state_n      = ST_RESP;
      resp_valid_n = 1'b1;
      resp_err_n   = err_c;
      rdata_en_n   = ~cur_c.we & ~err_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cap        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_en   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cap        <= cap_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      rdata_en   <= rdata_en_n;
    end
  end

  // The RAM read register is the load-data register; it stays stable in RESP
  // because the address is held and nothing writes. rdata_en zeroes it for
  // stores, errors and after reset.
  assign resp_rdata = rdata_en ? ram_dout : '0;

  memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (cur_c.addr[ADDR_WIDTH+1:2]),
    .din  (cur_c.wdata),
    .dout (ram_dout)
  );

endmodule
